// File: rtl/io_pkg.sv
// Shared definitions for the board-input conditioning path: default timing
// parameters, counter-width helper and the per-bit debounce state encoding.
package io_pkg;

  localparam int SAMPLE_CNT_MAX_DEF = 25000;
  localparam int PULSE_CNT_MAX_DEF  = 150;

  typedef enum logic [1:0] {
    DB_IDLE    = 2'd0,
    DB_ARMED   = 2'd1,
    DB_PRESSED = 2'd2
  } db_state_e;

  // Bits needed to hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One debounced input bit: saturating sample counter, registered level and
// single-cycle rise/fall pulses derived from the level and its delayed copy.
module debounce_cell
  import io_pkg::*;
#(
  parameter int PULSE_CNT_MAX = PULSE_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_in,
  input  logic tick,
  output logic level_out,
  output logic rise_out,
  output logic fall_out
);

  localparam int               CNT_W    = cnt_width(PULSE_CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(PULSE_CNT_MAX);

  logic [CNT_W-1:0] cnt_p0;
  logic             level_p1;
  logic             level_p2;
  db_state_e        state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_FULL) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    state = DB_IDLE;
    if (cnt_p0 == CNT_FULL) begin
      state = DB_PRESSED;
    end else if (cnt_p0 != '0) begin
      state = DB_ARMED;
    end
  end

  // Stage 0: a low input always wins, even while the scheduler is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (!sync_in) begin
      cnt_p0 <= '0;
    end else if (tick && en) begin
      cnt_p0 <= sat_inc(cnt_p0);
    end
  end

  // Stage 1/2: registered level and its one-cycle-delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_p1 <= 1'b0;
      level_p2 <= 1'b0;
    end else begin
      level_p1 <= (state == DB_PRESSED);
      level_p2 <= level_p1;
    end
  end

  assign level_out = level_p1;
  assign rise_out  = level_p1 & ~level_p2;
  assign fall_out  = ~level_p1 & level_p2;

endmodule

// File: rtl/synchronizer.sv
// Two-flop synchronizer bank bringing asynchronous pins into the clk domain.
module synchronizer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= async_in;
      sync_p1 <= sync_p0;
    end
  end

  assign sync_out = sync_p1;

endmodule

// File: rtl/input_conditioner.sv
// Board-input conditioner: synchronizes raw pins, debounces each bit against a
// shared sample-tick scheduler and reports levels plus edge pulses.
module input_conditioner
  import io_pkg::*;
#(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
  parameter int PULSE_CNT_MAX  = PULSE_CNT_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_out,
  output logic [WIDTH-1:0] fall_out,
  output logic             sample_tick
);

  localparam int               CTR_W    = cnt_width(SAMPLE_CNT_MAX - 1);
  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(SAMPLE_CNT_MAX - 1);

  logic [WIDTH-1:0] sync;
  logic [CTR_W-1:0] sample_ctr;

  synchronizer #(
    .WIDTH(WIDTH)
  ) u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .async_in(async_in),
    .sync_out(sync)
  );

  // Shared scheduler: frozen while disabled, tick only on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_ctr <= '0;
    end else if (en) begin
      sample_ctr <= (sample_ctr == CTR_LAST) ? '0 : sample_ctr + CTR_W'(1);
    end
  end

  assign sample_tick = en && (sample_ctr == CTR_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_cell #(
      .PULSE_CNT_MAX(PULSE_CNT_MAX)
    ) u_cell (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .sync_in  (sync[i]),
      .tick     (sample_tick),
      .level_out(level_out[i]),
      .rise_out (rise_out[i]),
      .fall_out (fall_out[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Scenario bench for input_conditioner with a cycle-level behavioural model.
module tb_input_conditioner;

  localparam int W = 2;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic [W-1:0] async_in = '0;
  logic [W-1:0] level_out, rise_out, fall_out;
  logic         sample_tick;

  int errors = 0;
  int checks = 0;

  input_conditioner #(
    .WIDTH(W), .SAMPLE_CNT_MAX(S), .PULSE_CNT_MAX(P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .async_in(async_in),
    .level_out(level_out), .rise_out(rise_out), .fall_out(fall_out),
    .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  // Behavioural model: pin history delayed two cycles, run-length of high samples.
  int   m_ctr;
  bit   m_s0 [W];
  bit   m_s1 [W];
  int   m_cnt [W];
  bit   m_lvl [W];
  bit   m_lvl_d [W];
  logic m_tick;
  logic [W-1:0] e_level, e_rise, e_fall;

  assign m_tick = en && (m_ctr == S - 1);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ctr <= 0;
      for (int i = 0; i < W; i++) begin
        m_s0[i] <= 0; m_s1[i] <= 0; m_cnt[i] <= 0; m_lvl[i] <= 0; m_lvl_d[i] <= 0;
      end
    end else begin
      if (en) m_ctr <= (m_ctr + 1) % S;
      for (int i = 0; i < W; i++) begin
        m_s0[i] <= async_in[i];
        m_s1[i] <= m_s0[i];
        if (!m_s1[i]) m_cnt[i] <= 0;
        else if (m_tick && m_cnt[i] < P) m_cnt[i] <= m_cnt[i] + 1;
        m_lvl[i]   <= (m_cnt[i] == P);
        m_lvl_d[i] <= m_lvl[i];
      end
    end
  end

  always_comb begin
    e_level = '0; e_rise = '0; e_fall = '0;
    for (int i = 0; i < W; i++) begin
      e_level[i] = m_lvl[i];
      e_rise[i]  = m_lvl[i] & ~m_lvl_d[i];
      e_fall[i]  = ~m_lvl[i] & m_lvl_d[i];
    end
  end

  wire [3*W:0] dut_vec = {level_out, rise_out, fall_out, sample_tick};
  wire [3*W:0] exp_vec = {e_level, e_rise, e_fall, m_tick};

  task automatic test_reset;
    en = 1'b1; async_in = 2'b01; rst_n = 1'b0;
    #12;
    checks++;
    if (dut_vec !== '0) begin
      errors++; $display("FAIL reset_state got=%b want=%b", dut_vec, 7'b0);
    end
    @(negedge clk); #3 rst_n = 1'b1;
  endtask

  task automatic test_press;
    int first = -1; int rises = 0; bit b1 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL press_model t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (level_out[0] && first < 0) first = n;
      rises += int'(rise_out[0]);
      if (level_out[1] || rise_out[1]) b1 = 1;
    end
    checks++;
    if (first < 1 || first > 15) begin
      errors++; $display("FAIL press_latency got=%0d want=1..15", first);
    end
    checks++;
    if (rises != 1) begin errors++; $display("FAIL press_rise_count got=%0d want=1", rises); end
    checks++;
    if (b1) begin errors++; $display("FAIL press_bit1_quiet got=1 want=0"); end
  endtask

  task automatic test_release;
    int lat = -1; int falls = 0;
    async_in[0] = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL release_model t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (!level_out[0] && lat < 0) lat = n;
      falls += int'(fall_out[0]);
    end
    checks++;
    if (lat != 4) begin errors++; $display("FAIL release_latency got=%0d want=4", lat); end
    checks++;
    if (falls != 1) begin errors++; $display("FAIL release_fall_count got=%0d want=1", falls); end
  endtask

  task automatic test_bounce;
    int rises = 0; bit seen = 0;
    for (int rep = 0; rep < 6; rep++) begin
      for (int k = 0; k < 7; k++) begin
        async_in[0] = (k < 6);
        async_in[1] = 1'($urandom_range(0, 1));
        @(negedge clk); checks++;
        if (dut_vec !== exp_vec) begin
          errors++; $display("FAIL bounce_model t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
        end
        rises += int'(rise_out[0]);
        if (level_out[0]) seen = 1;
      end
    end
    async_in = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL bounce_settle t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
    end
    checks++;
    if (rises != 0) begin errors++; $display("FAIL bounce_rises got=%0d want=0", rises); end
    checks++;
    if (seen) begin errors++; $display("FAIL bounce_level got=1 want=0"); end
  endtask

  task automatic test_tick_align;
    bit found = 0; bit bad = 0;
    async_in = 2'b10;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL align_model t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (m_cnt[1] == 2 && m_ctr == 1) found = 1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL align_timeout got=none want=cnt2"); end
    async_in[1] = 1'b0;
    @(negedge clk);
    @(negedge clk); checks++;
    if (sample_tick !== 1'b1) begin
      errors++; $display("FAIL align_tick got=%b want=1", sample_tick);
    end
    for (int n = 0; n < 12; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL align_after t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (level_out[1] || rise_out[1]) bad = 1;
    end
    checks++;
    if (bad) begin errors++; $display("FAIL align_no_rise got=1 want=0"); end
  endtask

  task automatic test_enable;
    bit ok; int ticks = 0; bit early = 0;
    async_in = 2'b01; ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); if (m_cnt[0] == 1) ok = 1;
    end
    en = 1'b0;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL enable_hold t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      ticks += int'(sample_tick);
    end
    checks++;
    if (ticks != 0) begin errors++; $display("FAIL enable_tick got=%0d want=0", ticks); end
    en = 1'b1; ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL enable_resume t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (level_out[0]) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL enable_complete got=0 want=1"); end
    async_in = '0;
    repeat (6) @(negedge clk);
    async_in = 2'b01; ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); if (m_cnt[0] == 1) ok = 1;
    end
    en = 1'b0; async_in = '0;
    repeat (4) @(negedge clk);
    en = 1'b1; async_in = 2'b01;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL enable_clear t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (level_out[0]) early = 1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL enable_cleared_cnt got=1 want=0"); end
  endtask

  task automatic test_reset_mid;
    bit ok; int first = -1;
    ok = 0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk); if (m_cnt[0] == 2 && !m_lvl[0]) ok = 1;
    end
    #3 rst_n = 1'b0;
    #1 checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL rst_armed got=%b want=0", dut_vec); end
    @(negedge clk); #3 rst_n = 1'b1;
    ok = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk); if (level_out[0]) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL rst_repress got=0 want=1"); end
    #7 rst_n = 1'b0;
    #1 checks++;
    if (dut_vec !== '0) begin errors++; $display("FAIL rst_pressed got=%b want=0", dut_vec); end
    @(negedge clk); #3 rst_n = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL rst_after t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
      if (level_out[0] && first < 0) first = n;
    end
    checks++;
    if (first != 13) begin errors++; $display("FAIL rst_full_debounce got=%0d want=13", first); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 19) == 0) async_in[0] = ~async_in[0];
      if ($urandom_range(0, 19) == 0) async_in[1] = ~async_in[1];
      if ($urandom_range(0, 49) == 0) en = ~en;
      @(negedge clk); checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("FAIL random_model t=%0t got=%b want=%b", $time, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_tick_align();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
